// File: rtl/yp_fifo_stream_out.sv
// Turns a one-cycle-latency synchronous FIFO read port into a valid/ready stream
// with fixed-length packet framing (sop/eop) and a completed-packet counter.
module yp_fifo_stream_out #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic [15:0]           o_pkt_cnt
);
  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);

  logic [1:0]            occ_q, occ_d, occ_m;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [7:0]            beat_q, beat_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  pop;
  logic [2:0]            lvl;

  assign o_valid   = (occ_q != 2'd0);
  assign o_data    = e0_q;
  assign o_sop     = o_valid & (beat_q == 8'd0);
  assign o_eop     = o_valid & (beat_q == LAST);
  assign o_pkt_cnt = pkt_cnt_q;
  assign pop       = o_valid & i_ready;

  // Buffer slots plus the in-flight read may never exceed two after this cycle's pop.
  assign lvl          = {1'b0, occ_q} + {2'b0, inflight_q};
  assign o_fifo_rd_en = i_rstn & ~i_fifo_empty & ~i_flush & (lvl < (3'd2 + {2'b0, pop}));

  always_comb begin
    e0_d       = e0_q;
    e1_d       = e1_q;
    occ_m      = occ_q - {1'b0, pop};
    occ_d      = occ_m + {1'b0, inflight_q};
    inflight_d = o_fifo_rd_en;
    beat_d     = beat_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (pop) begin
      e0_d   = e1_q;
      beat_d = (beat_q == LAST) ? 8'd0 : beat_q + 8'd1;
      if (o_eop) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    // Returning data lands behind whatever survives this cycle's pop.
    if (inflight_q) begin
      if (occ_m == 2'd0) e0_d = i_fifo_data;
      else               e1_d = i_fifo_data;
    end
    if (i_flush) begin
      occ_d      = 2'd0;
      inflight_d = 1'b0;
      beat_d     = 8'd0;
      pkt_cnt_d  = pkt_cnt_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
      beat_q     <= 8'd0;
      pkt_cnt_q  <= 16'd0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      beat_q     <= beat_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end
endmodule

// File: tb/tb_yp_fifo_stream_out.sv
// Scoreboard bench: words written into a FIFO model are expected in order on the stream.
module tb_yp_fifo_stream_out;
  localparam int DW = 8;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rstn, flush, ready;
  logic          fifo_empty, rd_en, valid, sop, eop;
  logic [DW-1:0] fifo_data = '0, data;
  logic [15:0]   pkt_cnt;

  always #5 clk = ~clk;

  yp_fifo_stream_out #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
    .o_fifo_rd_en(rd_en), .i_flush(flush), .o_valid(valid), .i_ready(ready),
    .o_data(data), .o_sop(sop), .o_eop(eop), .o_pkt_cnt(pkt_cnt)
  );

  // FIFO model with one-cycle read latency
  logic [DW-1:0] mem [0:2047];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk)
    if (rd_en && !fifo_empty) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  bit            chk_pkt = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wr_word(input logic [DW-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
    exp_q.push_back(d);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rd_ptr != wr_ptr) && n < budget) begin cyc(1); n++; end
    chk("drain_timeout", 32'(n >= budget), 0);
    cyc(2);
  endtask

  task automatic do_flush();
    flush = 1'b1; cyc(1); flush = 1'b0;
  endtask

  // Monitor: transfers, framing, packet count, stall stability, occupancy bound
  int            acc_n = 0, tx_n = 0, bbeat = 0;
  logic [15:0]   mpkt = 0;
  bit            hold_v = 0;
  logic [DW-1:0] hold_d;
  logic          hold_s, hold_e;
  always @(negedge clk) begin
    chk("occ_bound", 32'(dut.occ_q > 2'd2), 0);
    if (hold_v && valid && rstn && !flush) begin
      chk("hold_data", 32'(data), 32'(hold_d));
      chk("hold_sop", 32'(sop), 32'(hold_s));
      chk("hold_eop", 32'(eop), 32'(hold_e));
    end
    if (flush || !rstn) begin
      repeat (acc_n - tx_n) if (exp_q.size() != 0) void'(exp_q.pop_front());
      acc_n  = tx_n;
      bbeat  = 0;
      hold_v = 0;
      if (!rstn) mpkt = 0;
    end else begin
      if (rd_en && !fifo_empty) acc_n++;
      if (valid && ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 32'(data), 32'hDEAD);
        else chk("data", 32'(data), 32'(exp_q.pop_front()));
        chk("sop", 32'(sop), 32'(bbeat == 0));
        chk("eop", 32'(eop), 32'(bbeat == PL - 1));
        if (chk_pkt) chk("pkt_cnt", 32'(pkt_cnt), 32'(mpkt));
        tx_n++;
        if (bbeat == PL - 1) begin bbeat = 0; mpkt = mpkt + 16'd1; end
        else bbeat++;
      end
      hold_v = valid && !ready;
      hold_d = data; hold_s = sop; hold_e = eop;
    end
  end

  initial begin
    int          r0, n;
    logic [15:0] pk0;
    rstn = 1'b0; flush = 1'b0; ready = 1'b0;
    cyc(3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_pkt", 32'(pkt_cnt), 0);
    chk("rst_data", 32'(data), 0);
    rstn = 1'b1;
    cyc(2);

    // Preloaded burst: latency and framing
    ready = 1'b1;
    for (int i = 0; i < 8; i++) wr_word(DW'(8'h10 + i));
    @(negedge clk); chk("lat_rd_c0", 32'(rd_en), 1); chk("lat_v_c0", 32'(valid), 0);
    @(negedge clk); chk("lat_v_c1", 32'(valid), 0);
    @(negedge clk); chk("lat_v_c2", 32'(valid), 1); chk("lat_d_c2", 32'(data), 32'h10);
    #1; drain(100);
    chk("burst_pkt", 32'(pkt_cnt), 2);

    // Backpressure: only two reads accepted, head frozen
    ready = 1'b0;
    r0 = rd_ptr;
    for (int i = 0; i < 6; i++) wr_word(DW'(8'h30 + i));
    cyc(10);
    chk("bp_reads", 32'(rd_ptr - r0), 2);
    chk("bp_valid", 32'(valid), 1);
    chk("bp_data", 32'(data), 32'h30);
    ready = 1'b1;
    drain(100);
    do_flush(); cyc(1);

    // Random traffic: 1000 words, random ready
    pk0 = pkt_cnt;
    n = 0;
    for (int c = 0; c < 20000 && (n < 1000 || exp_q.size() != 0); c++) begin
      ready = 1'($urandom_range(0, 1));
      if (n < 1000 && $urandom_range(0, 1) == 1) begin wr_word(DW'($urandom)); n++; end
      cyc(1);
    end
    ready = 1'b1;
    drain(100);
    chk("rand_pkts", 32'(16'(pkt_cnt - pk0)), 250);

    // Flush after beat 2 with a read in flight
    pk0 = pkt_cnt;
    for (int i = 0; i < 8; i++) wr_word(DW'(8'h50 + i));
    n = 0;
    while (bbeat != 2 && n < 50) begin cyc(1); n++; end
    chk("fl_reach_timeout", 32'(n >= 50), 0);
    chk("fl_inflight", 32'(dut.inflight_q), 1);
    do_flush();
    chk("fl_valid", 32'(valid), 0);
    chk("fl_pkt", 32'(pkt_cnt), 32'(pk0));
    n = 0;
    while (!valid && n < 20) begin cyc(1); n++; end
    chk("fl_next_sop", 32'(sop), 1);
    drain(100);
    do_flush(); cyc(1);

    // Async reset mid-stream with a full buffer
    ready = 1'b0;
    for (int i = 0; i < 4; i++) wr_word(DW'(8'h70 + i));
    cyc(5);
    chk("ar_pre_valid", 32'(valid), 1);
    rstn = 1'b0; #1;
    chk("ar_valid", 32'(valid), 0);
    chk("ar_rd_en", 32'(rd_en), 0);
    chk("ar_sop", 32'(sop), 0);
    chk("ar_eop", 32'(eop), 0);
    chk("ar_data", 32'(data), 0);
    chk("ar_pkt", 32'(pkt_cnt), 0);
    cyc(2);
    rstn = 1'b1; ready = 1'b1;
    n = 0;
    while (!valid && n < 20) begin cyc(1); n++; end
    chk("ar_restart_sop", 32'(sop), 1);
    drain(100);
    chk("ar_pkt_after", 32'(pkt_cnt), 0);
    do_flush(); cyc(1);

    // Packet counter wrap
    chk_pkt = 1'b0;
    force dut.pkt_cnt_q = 16'hFFFF;
    #2;
    release dut.pkt_cnt_q;
    cyc(1);
    chk("wrap_pre", 32'(pkt_cnt), 32'hFFFF);
    for (int i = 0; i < PL; i++) wr_word(DW'(8'hA0 + i));
    drain(100);
    chk("wrap_post", 32'(pkt_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
